// File: rtl/bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bus_responder : 8085 multiplexed-bus slave - window decode, READY wait
//                 states, internal byte RAM served over the AD bus.
// Revision      : 1.0
// ============================================================================
module bus_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter bit          IO_SPACE  = 1'b0,
    parameter int          WAIT_CNT  = 1
) (
    input  logic       clk_,
    input  logic       rst_,
    input  logic       ale,
    input  logic [7:0] addh,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic       rd_,
    input  logic       wr_,
    input  logic       iom_,
    input  logic       s1,
    input  logic       s0,
    output logic       ready,
    output logic       sel,
    output logic       err
);

    localparam int          DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CNT);
    localparam logic [16:0] MEM_LO    = {1'b0, BASE_ADDR};
    localparam logic [16:0] IO_LO     = {9'd0, BASE_ADDR[7:0]};
    localparam logic [16:0] WIN_SIZE  = 17'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [7:0]           ad_out_q, ad_out_d;
    logic                 rd_cyc_q, rd_cyc_d;
    logic                 ad_oe_q, ad_oe_d;
    logic                 ready_q, ready_d;
    logic                 sel_q, sel_d;
    logic                 err_q, err_d;
    logic                 ram_we;
    logic [7:0]           ram_q [DEPTH];

    logic [15:0] w_bus_addr;
    logic [16:0] w_mem_off;
    logic [16:0] w_io_off;
    logic        w_in_window;
    logic        w_hit;
    logic        w_relatch;

    // Offsets are taken one bit wider so an address below the base wraps to a
    // value far above the window size instead of aliasing into it.
    assign w_bus_addr  = {addh, ad_in};
    assign w_mem_off   = {1'b0, w_bus_addr} - MEM_LO;
    assign w_io_off    = {9'd0, ad_in} - IO_LO;
    assign w_in_window = iom_ ? (w_io_off < WIN_SIZE) : (w_mem_off < WIN_SIZE);
    assign w_hit       = (iom_ == IO_SPACE) && ({s1, s0} != 2'b00)
                         && !(iom_ && s1 && s0) && w_in_window;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wcnt_d    = wcnt_q;
        wdata_d   = wdata_q;
        ad_out_d  = ad_out_q;
        rd_cyc_d  = rd_cyc_q;
        ad_oe_d   = ad_oe_q;
        ready_d   = ready_q;
        sel_d     = sel_q;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        w_relatch = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_relatch = ale;
            end
            ST_ADDR, ST_ACCESS: begin
                if (ale) begin
                    // Abandoned cycle: release the bus, then decode the new address.
                    err_d     = 1'b1;
                    ad_oe_d   = 1'b0;
                    sel_d     = 1'b0;
                    ready_d   = 1'b1;
                    state_d   = ST_IDLE;
                    w_relatch = 1'b1;
                end else if (state_q == ST_ADDR && wcnt_q != 4'd0) begin
                    wcnt_d  = wcnt_q - 4'd1;
                    ready_d = (wcnt_q == 4'd1);
                end else if (!rd_ && !wr_) begin
                    err_d   = 1'b1;
                    ad_oe_d = 1'b0;
                    sel_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_ADDR) begin
                    if (!rd_) begin
                        ad_out_d = ram_q[addr_q];
                        ad_oe_d  = 1'b1;
                        rd_cyc_d = 1'b1;
                        state_d  = ST_ACCESS;
                    end else if (!wr_) begin
                        wdata_d  = ad_in;
                        rd_cyc_d = 1'b0;
                        state_d  = ST_ACCESS;
                    end
                end else if (rd_cyc_q) begin
                    if (rd_) begin
                        ad_oe_d = 1'b0;
                        sel_d   = 1'b0;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (!wr_) begin
                    wdata_d = ad_in;
                end else begin
                    ram_we  = 1'b1;
                    sel_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_relatch) begin
            addr_d = w_bus_addr[ADDR_BITS-1:0];
            wcnt_d = WAIT_INIT;
            if (w_hit) begin
                state_d = ST_ADDR;
                sel_d   = 1'b1;
                ready_d = (WAIT_CNT == 0);
            end
        end
    end

    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wcnt_q   <= 4'd0;
            wdata_q  <= 8'd0;
            ad_out_q <= 8'd0;
            rd_cyc_q <= 1'b0;
            ad_oe_q  <= 1'b0;
            ready_q  <= 1'b1;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            wdata_q  <= wdata_d;
            ad_out_q <= ad_out_d;
            rd_cyc_q <= rd_cyc_d;
            ad_oe_q  <= ad_oe_d;
            ready_q  <= ready_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_) begin
        if (ram_we) begin
            ram_q[addr_q] <= wdata_q;
        end
    end

    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign ready  = ready_q;
    assign sel    = sel_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_bus_responder : drives 8085 bus cycles into four responder variants and
//                    checks every cycle against a transaction-level model.
// Revision         : 1.0
// ============================================================================
module tb_bus_responder;

    localparam int NI     = 4;
    localparam int BASE_I = 'h2000;

    logic       clk_ = 1'b0;
    logic       rst_ = 1'b1;
    logic       ale = 1'b0;
    logic [7:0] addh = 8'd0;
    logic [7:0] ad_in = 8'd0;
    logic       rd_ = 1'b1;
    logic       wr_ = 1'b1;
    logic       iom_ = 1'b0;
    logic       s1 = 1'b0;
    logic       s0 = 1'b0;

    logic [7:0]    out_w [NI];
    logic [NI-1:0] oe_w, ready_w, sel_w, err_w;

    logic [7:0]    mem_m   [NI][256];
    logic [7:0]    cur_out [NI];
    logic [7:0]    e_out   [NI];
    logic [NI-1:0] e_sel, e_ready, e_oe, e_err;

    int n_chk  = 0;
    int n_fail = 0;
    int low_cnt [NI];
    int sel_cnt [NI];
    int oe_cnt  [NI];
    int err_cnt [NI];

    always #5 clk_ = ~clk_;

    bus_responder #(.ADDR_BITS(8), .BASE_ADDR(16'h2000), .IO_SPACE(1'b0), .WAIT_CNT(0)) u_w0 (
        .clk_(clk_), .rst_(rst_), .ale(ale), .addh(addh), .ad_in(ad_in), .ad_out(out_w[0]),
        .ad_oe(oe_w[0]), .rd_(rd_), .wr_(wr_), .iom_(iom_), .s1(s1), .s0(s0),
        .ready(ready_w[0]), .sel(sel_w[0]), .err(err_w[0]));
    bus_responder #(.ADDR_BITS(8), .BASE_ADDR(16'h2000), .IO_SPACE(1'b0), .WAIT_CNT(1)) u_w1 (
        .clk_(clk_), .rst_(rst_), .ale(ale), .addh(addh), .ad_in(ad_in), .ad_out(out_w[1]),
        .ad_oe(oe_w[1]), .rd_(rd_), .wr_(wr_), .iom_(iom_), .s1(s1), .s0(s0),
        .ready(ready_w[1]), .sel(sel_w[1]), .err(err_w[1]));
    bus_responder #(.ADDR_BITS(8), .BASE_ADDR(16'h2000), .IO_SPACE(1'b0), .WAIT_CNT(3)) u_w3 (
        .clk_(clk_), .rst_(rst_), .ale(ale), .addh(addh), .ad_in(ad_in), .ad_out(out_w[2]),
        .ad_oe(oe_w[2]), .rd_(rd_), .wr_(wr_), .iom_(iom_), .s1(s1), .s0(s0),
        .ready(ready_w[2]), .sel(sel_w[2]), .err(err_w[2]));
    bus_responder #(.ADDR_BITS(8), .BASE_ADDR(16'h2000), .IO_SPACE(1'b1), .WAIT_CNT(2)) u_io (
        .clk_(clk_), .rst_(rst_), .ale(ale), .addh(addh), .ad_in(ad_in), .ad_out(out_w[3]),
        .ad_oe(oe_w[3]), .rd_(rd_), .wr_(wr_), .iom_(iom_), .s1(s1), .s0(s0),
        .ready(ready_w[3]), .sel(sel_w[3]), .err(err_w[3]));

    function automatic int wait_of(int i);
        case (i)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit io_of(int i);
        return (i == 3);
    endfunction

    // Decode rule straight from the address map: window, space, status, INTA.
    function automatic bit hit(int i, logic [15:0] adr, bit io, logic [1:0] s);
        int lo;
        if (io != io_of(i)) return 1'b0;
        if (s == 2'b00) return 1'b0;
        if (io && s == 2'b11) return 1'b0;
        if (io) begin
            lo = BASE_I % 256;
            return (int'(adr[7:0]) >= lo) && (int'(adr[7:0]) < lo + 256);
        end
        return (int'(adr) >= BASE_I) && (int'(adr) < BASE_I + 256);
    endfunction

    task automatic chk(string name, int inst, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    always @(posedge clk_) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("sel",    i, 8'(sel_w[i]),   8'(e_sel[i]));
            chk("ready",  i, 8'(ready_w[i]), 8'(e_ready[i]));
            chk("ad_oe",  i, 8'(oe_w[i]),    8'(e_oe[i]));
            chk("err",    i, 8'(err_w[i]),   8'(e_err[i]));
            chk("ad_out", i, out_w[i],       e_out[i]);
        end
    end

    always @(posedge clk_) begin
        #2;
        for (int i = 0; i < NI; i++) begin
            if (!ready_w[i]) low_cnt[i]++;
            if (sel_w[i])    sel_cnt[i]++;
            if (oe_w[i])     oe_cnt[i]++;
            if (err_w[i])    err_cnt[i]++;
        end
    end

    task automatic clr_cnt();
        for (int i = 0; i < NI; i++) begin
            low_cnt[i] = 0; sel_cnt[i] = 0; oe_cnt[i] = 0; err_cnt[i] = 0;
        end
    endtask

    task automatic set_idle_exp();
        for (int i = 0; i < NI; i++) begin
            e_sel[i] = 1'b0; e_ready[i] = 1'b1; e_oe[i] = 1'b0; e_err[i] = 1'b0;
            e_out[i] = cur_out[i];
        end
    endtask

    task automatic step(bit a, logic [15:0] adr, logic [7:0] d, bit r, bit w, bit io, logic [1:0] s);
        @(negedge clk_);
        ale  = a;
        if (a) addh = adr[15:8];
        ad_in = a ? adr[7:0] : d;
        rd_  = r;
        wr_  = w;
        iom_ = io;
        {s1, s0} = s;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 2'b00);
            set_idle_exp();
        end
    endtask

    // One bus cycle: step 0 is ALE, strobe low on steps a..b (or both strobes on
    // step v for a violation), released afterwards. cut>0 stops after cut steps.
    task automatic run_txn(input logic [15:0] adr, input bit io, input logic [1:0] s,
                           input bit is_wr, input int a, input int b, input int v,
                           input logic [NI-1:0] abn, input int cut, input logic [8:0] wd,
                           output logic [NI-1:0] hm);
        logic [7:0] dat [16];
        int last;
        last = (v >= 0) ? v + 1 : b + 1;
        if (cut > 0) last = cut - 1;
        for (int i = 0; i < NI; i++) hm[i] = hit(i, adr, io, s);
        for (int k = 0; k <= last; k++) begin
            bit lo_r, lo_w;
            dat[k] = wd[8] ? wd[7:0] : 8'($urandom);
            if (v >= 0) begin
                lo_r = (k == v);
                lo_w = (k == v);
            end else begin
                lo_r = !is_wr && (k >= a) && (k <= b);
                lo_w = is_wr && (k >= a) && (k <= b);
            end
            step(k == 0, adr, dat[k], !lo_r, !lo_w, io, s);
            for (int i = 0; i < NI; i++) begin
                int wt, c, d;
                wt = wait_of(i);
                c  = (a > wt + 1) ? a : wt + 1;
                d  = (v >= 0) ? v : b + 1;
                if (!hm[i] || k > d) begin
                    e_sel[i] = 1'b0; e_ready[i] = 1'b1; e_oe[i] = 1'b0;
                    e_err[i] = (k == 0) && abn[i];
                end else if (k < d) begin
                    e_sel[i]   = 1'b1;
                    e_ready[i] = (k >= wt);
                    e_err[i]   = (k == 0) && abn[i];
                    e_oe[i]    = (v < 0) && !is_wr && (k >= c);
                    if (e_oe[i] && k == c) cur_out[i] = mem_m[i][adr[7:0]];
                end else begin
                    e_sel[i] = 1'b0; e_ready[i] = 1'b1; e_oe[i] = 1'b0;
                    e_err[i] = (v >= 0);
                    if (v < 0 && is_wr) mem_m[i][adr[7:0]] = dat[b];
                end
                e_out[i] = cur_out[i];
            end
        end
    endtask

    initial begin
        logic [NI-1:0] hm, hm1, pend;
        logic [15:0]   adr;
        logic [7:0]    p;
        bit            io, is_wr;
        logic [1:0]    s;
        int            a, b, v, cut;

        for (int i = 0; i < NI; i++) cur_out[i] = 8'h00;
        set_idle_exp();
        clr_cnt();
        #1 rst_ = 1'b0;
        #3;
        for (int i = 0; i < NI; i++) begin
            chk("rst_sel",   i, 8'(sel_w[i]),   8'h00);
            chk("rst_ready", i, 8'(ready_w[i]), 8'h01);
            chk("rst_oe",    i, 8'(oe_w[i]),    8'h00);
            chk("rst_out",   i, out_w[i],       8'h00);
        end
        repeat (2) @(negedge clk_);
        rst_ = 1'b1;

        for (int k = 0; k < 256; k++) begin
            p = 8'(k);
            run_txn({8'h20, p}, 1'b0, 2'b01, 1'b1, 1, 4, -1, '0, 0, 9'h000, hm);
        end
        for (int k = 0; k < 256; k++) begin
            p = 8'(k);
            run_txn({p, p}, 1'b1, 2'b01, 1'b1, 1, 4, -1, '0, 0, 9'h000, hm);
        end

        // Memory read of 2010 with RD_ asserted during the wait states.
        idle(1); clr_cnt();
        run_txn(16'h2010, 1'b0, 2'b10, 1'b0, 1, 5, -1, '0, 0, 9'h000, hm);
        idle(1);
        chk("lowcnt_w0", 0, 8'(low_cnt[0]), 8'd0);
        chk("lowcnt_w1", 1, 8'(low_cnt[1]), 8'd1);
        chk("lowcnt_w3", 2, 8'(low_cnt[2]), 8'd3);
        chk("selcnt_w1", 1, 8'(sel_cnt[1]), 8'd6);
        chk("oecnt_w0",  0, 8'(oe_cnt[0]),  8'd5);
        chk("oecnt_w3",  2, 8'(oe_cnt[2]),  8'd2);

        // Write A5 to the window top, then read it back.
        clr_cnt();
        run_txn(16'h20FF, 1'b0, 2'b01, 1'b1, 1, 4, -1, '0, 0, 9'h1A5, hm);
        idle(1);
        chk("wr_lowcnt_w0", 0, 8'(low_cnt[0]), 8'd0);
        for (int i = 0; i < NI; i++) chk("wr_oecnt", i, 8'(oe_cnt[i]), 8'd0);
        run_txn(16'h20FF, 1'b0, 2'b10, 1'b0, 1, 4, -1, '0, 0, 9'h000, hm);
        idle(1);
        for (int i = 0; i < 3; i++) chk("rdback_A5", i, out_w[i], 8'hA5);

        // Decode misses: past top, below base, halt status, INTA.
        clr_cnt();
        run_txn(16'h2100, 1'b0, 2'b10, 1'b0, 1, 4, -1, '0, 0, 9'h000, hm);
        run_txn(16'h1FFF, 1'b0, 2'b10, 1'b0, 1, 4, -1, '0, 0, 9'h000, hm);
        run_txn(16'h2040, 1'b0, 2'b00, 1'b0, 1, 4, -1, '0, 0, 9'h000, hm);
        run_txn(16'h4242, 1'b1, 2'b11, 1'b0, 1, 4, -1, '0, 0, 9'h000, hm);
        idle(1);
        for (int i = 0; i < NI; i++) begin
            chk("miss_selcnt", i, 8'(sel_cnt[i]), 8'd0);
            chk("miss_lowcnt", i, 8'(low_cnt[i]), 8'd0);
            chk("miss_oecnt",  i, 8'(oe_cnt[i]),  8'd0);
        end
        clr_cnt();
        run_txn(16'h3333, 1'b1, 2'b10, 1'b0, 1, 4, -1, '0, 0, 9'h000, hm);
        idle(1);
        for (int i = 0; i < 3; i++) chk("io_selcnt", i, 8'(sel_cnt[i]), 8'd0);

        // Both strobes low together: error, no write.
        clr_cnt();
        run_txn(16'h2040, 1'b0, 2'b01, 1'b1, 4, 4, 4, '0, 0, 9'h1C3, hm);
        idle(1);
        for (int i = 0; i < 3; i++) chk("viol_errcnt", i, 8'(err_cnt[i]), 8'd1);
        run_txn(16'h2040, 1'b0, 2'b10, 1'b0, 1, 4, -1, '0, 0, 9'h000, hm);

        // ALE reasserted mid-write: original address left untouched.
        idle(1); clr_cnt();
        run_txn(16'h2033, 1'b0, 2'b01, 1'b1, 1, 10, -1, '0, 4, 9'h15A, hm1);
        run_txn(16'h2077, 1'b0, 2'b10, 1'b0, 1, 5, -1, hm1, 0, 9'h000, hm);
        idle(1);
        for (int i = 0; i < 3; i++) chk("abn_errcnt", i, 8'(err_cnt[i]), 8'd1);
        run_txn(16'h2033, 1'b0, 2'b10, 1'b0, 1, 4, -1, '0, 0, 9'h000, hm);

        // Asynchronous reset while the read data is on the bus.
        run_txn(16'h2010, 1'b0, 2'b10, 1'b0, 1, 10, -1, '0, 7, 9'h000, hm);
        @(posedge clk_);
        #3;
        rst_ = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("arst_oe",    i, 8'(oe_w[i]),    8'h00);
            chk("arst_ready", i, 8'(ready_w[i]), 8'h01);
            chk("arst_sel",   i, 8'(sel_w[i]),   8'h00);
            cur_out[i] = 8'h00;
        end
        set_idle_exp();
        ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1;
        @(negedge clk_);
        rst_ = 1'b1;
        run_txn(16'h2010, 1'b0, 2'b10, 1'b0, 2, 6, -1, '0, 0, 9'h000, hm);

        // Randomized cycles, including abandoned ones and strobe violations.
        pend = '0;
        for (int t = 0; t < 200; t++) begin
            is_wr = 1'($urandom_range(0, 1));
            io    = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0:       adr = 16'h1FFF;
                1:       adr = 16'h2000;
                2:       adr = 16'h20FF;
                3:       adr = 16'h2100;
                4:       adr = {8'h20, 8'($urandom)};
                default: adr = 16'($urandom);
            endcase
            if (io) begin
                p   = 8'($urandom);
                adr = {p, p};
            end
            s = is_wr ? 2'b01 : 2'b10;
            if ($urandom_range(0, 7) == 0) s = 2'($urandom_range(0, 3));
            a = $urandom_range(1, 3);
            b = a + 3 + $urandom_range(0, 2);
            v = -1;
            if ($urandom_range(0, 7) == 0) begin
                v = 4 + $urandom_range(0, 1);
                a = v;
                b = v;
            end
            cut = 0;
            if (t < 199 && v < 0 && $urandom_range(0, 9) == 0) cut = $urandom_range(2, 5);
            run_txn(adr, io, s, is_wr, a, b, v, pend, cut, 9'h000, hm);
            pend = (cut > 0) ? hm : '0;
        end

        idle(2);
        @(posedge clk_);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
